// File: rtl/dphy_hs_sequencer.sv
// Per-link HS burst sequencer: filters LP state, times HS settle, gates the byte aligners
// and issues a fixed-phase word-rate enable, bounding each burst with sync/length timeouts.
module dphy_hs_sequencer #(
  parameter int LP_FILTER    = 3,
  parameter int SETTLE_CYC   = 24,
  parameter int SYNC_TIMEOUT = 64,
  parameter int MAX_LEN      = 8192
) (
  input  logic        dphy_clk,
  input  logic        areset,
  input  logic        i_lp_active,
  input  logic        i_sync_seen,
  input  logic        i_packet_done,
  output logic        o_word_ce,
  output logic        o_rx_reset,
  output logic        o_wait_for_sync,
  output logic        o_hs_active,
  output logic        o_timeout_err,
  output logic [15:0] o_pkt_count,
  output logic [7:0]  o_err_count
);

  typedef enum logic [2:0] {LP_IDLE, SETTLE, SYNC_WAIT, RECEIVE, DRAIN} state_t;

  localparam logic [3:0]  FLT_LAST  = 4'(LP_FILTER - 1);
  localparam logic [7:0]  SET_LAST  = 8'(SETTLE_CYC - 1);
  localparam logic [15:0] SYNC_LAST = 16'(SYNC_TIMEOUT - 1);
  localparam logic [15:0] LEN_LAST  = 16'(MAX_LEN - 1);

  state_t      r_state, w_state_nxt;
  logic        r_lp_s1, r_lp_s2, r_lp_f;
  logic [3:0]  r_flt_cnt;
  logic [1:0]  r_phase, w_phase_nxt;
  logic [7:0]  r_cyc_cnt;
  logic [15:0] r_word_cnt;
  logic        r_word_ce, r_rx_reset, r_wait_sync, r_hs_active, r_timeout_err;
  logic [15:0] r_pkt_count;
  logic [7:0]  r_err_count;
  logic        w_err, w_pkt, w_word_clr, w_word_inc;
  logic        w_rx_reset, w_wait_sync, w_hs_active;

  // LP comparator is asynchronous: two-flop sync, then require LP_FILTER agreeing samples
  always_ff @(posedge dphy_clk or posedge areset) begin
    if (areset) begin
      r_lp_s1   <= 1'b1;
      r_lp_s2   <= 1'b1;
      r_lp_f    <= 1'b1;
      r_flt_cnt <= '0;
    end else begin
      r_lp_s1 <= i_lp_active;
      r_lp_s2 <= r_lp_s1;
      if (r_lp_s2 != r_lp_f) begin
        if (r_flt_cnt == FLT_LAST) begin
          r_lp_f    <= r_lp_s2;
          r_flt_cnt <= '0;
        end else begin
          r_flt_cnt <= r_flt_cnt + 4'd1;
        end
      end else begin
        r_flt_cnt <= '0;
      end
    end
  end

  always_ff @(posedge dphy_clk or posedge areset) begin
    if (areset) r_state <= LP_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_err       = 1'b0;
    w_pkt       = 1'b0;
    w_word_clr  = 1'b0;
    w_word_inc  = 1'b0;
    case (r_state)
      LP_IDLE: if (!r_lp_f) w_state_nxt = SETTLE;
      SETTLE: begin
        if (r_lp_f) w_state_nxt = LP_IDLE;
        else if (r_cyc_cnt == SET_LAST) begin
          w_state_nxt = SYNC_WAIT;
          w_word_clr  = 1'b1;
        end
      end
      SYNC_WAIT: begin
        if (r_lp_f) begin
          w_state_nxt = LP_IDLE;
          w_err       = 1'b1;
        end else if (r_word_ce && i_sync_seen) begin
          w_state_nxt = RECEIVE;
          w_word_clr  = 1'b1;
        end else if (r_word_ce && r_word_cnt == SYNC_LAST) begin
          w_state_nxt = DRAIN;
          w_err       = 1'b1;
        end else if (r_word_ce) w_word_inc = 1'b1;
      end
      RECEIVE: begin
        // end-of-packet outranks the length timeout on the same word
        if (r_lp_f) begin
          w_state_nxt = LP_IDLE;
          w_err       = 1'b1;
        end else if (r_word_ce && i_packet_done) begin
          w_state_nxt = DRAIN;
          w_pkt       = 1'b1;
        end else if (r_word_ce && r_word_cnt == LEN_LAST) begin
          w_state_nxt = DRAIN;
          w_err       = 1'b1;
        end else if (r_word_ce) w_word_inc = 1'b1;
      end
      DRAIN:   if (r_lp_f) w_state_nxt = LP_IDLE;
      default: w_state_nxt = LP_IDLE;
    endcase
  end

  always_comb begin
    w_rx_reset  = 1'b1;
    w_wait_sync = 1'b1;
    w_hs_active = 1'b0;
    case (r_state)
      SYNC_WAIT: begin
        w_rx_reset  = 1'b0;
        w_hs_active = 1'b1;
      end
      RECEIVE: begin
        w_rx_reset  = 1'b0;
        w_wait_sync = 1'b0;
        w_hs_active = 1'b1;
      end
      default: ;
    endcase
  end

  // Word phase restarts at each burst so word boundaries land at a fixed offset from settle
  assign w_phase_nxt = (r_state == LP_IDLE && w_state_nxt == SETTLE) ? 2'd0 : r_phase + 2'd1;

  always_ff @(posedge dphy_clk or posedge areset) begin
    if (areset) begin
      r_phase       <= '0;
      r_word_ce     <= 1'b0;
      r_cyc_cnt     <= '0;
      r_word_cnt    <= '0;
      r_rx_reset    <= 1'b1;
      r_wait_sync   <= 1'b1;
      r_hs_active   <= 1'b0;
      r_timeout_err <= 1'b0;
      r_pkt_count   <= '0;
      r_err_count   <= '0;
    end else begin
      r_phase       <= w_phase_nxt;
      r_word_ce     <= (w_phase_nxt == 2'd3);
      r_cyc_cnt     <= (r_state == SETTLE) ? r_cyc_cnt + 8'd1 : 8'd0;
      if (w_word_clr)      r_word_cnt <= '0;
      else if (w_word_inc) r_word_cnt <= r_word_cnt + 16'd1;
      r_rx_reset    <= w_rx_reset;
      r_wait_sync   <= w_wait_sync;
      r_hs_active   <= w_hs_active;
      r_timeout_err <= w_err;
      if (w_err && r_err_count != 8'hFF)   r_err_count <= r_err_count + 8'd1;
      if (w_pkt && r_pkt_count != 16'hFFFF) r_pkt_count <= r_pkt_count + 16'd1;
    end
  end

  assign o_word_ce       = r_word_ce;
  assign o_rx_reset      = r_rx_reset;
  assign o_wait_for_sync = r_wait_sync;
  assign o_hs_active     = r_hs_active;
  assign o_timeout_err   = r_timeout_err;
  assign o_pkt_count     = r_pkt_count;
  assign o_err_count     = r_err_count;

endmodule
